// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared operation encodings for the bit-slice ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_bit.sv
`default_nettype none
// ============================================================================
// Module      : alu_bit
// Description : One ALU bit: AND / OR / full-adder sum / XOR with optional
//               B inversion. Carry-out is always the full-adder carry,
//               whatever the selected operation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       b_invert,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout
);

    logic w_bb;
    logic w_prop;
    logic w_sum;

    // B inversion is shared by every operation so subtract is ADD with ~b and cin=1
    assign w_bb   = b_invert ? ~b : b;
    assign w_prop = a ^ w_bb;
    assign w_sum  = w_prop ^ cin;
    assign cout   = (a & w_bb) | (cin & w_prop);

    // Select the per-bit result for the requested operation
    always_comb begin
        result = 1'b0;
        case (operation)
            OP_AND:  result = a & w_bb;
            OP_OR:   result = a | w_bb;
            OP_ADD:  result = w_sum;
            OP_XOR:  result = w_prop;
            default: result = 1'b0;
        endcase
    end

endmodule : alu_bit
`default_nettype wire

// File: rtl/alu_1bit_slice.sv
`default_nettype none
// ============================================================================
// Module      : alu_1bit_slice
// Description : WIDTH-bit ripple ALU built from alu_bit slices. result/cout
//               are combinational; result_q/cout_q are a registered copy.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_1bit_slice
    import alu_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             b_invert,
    input  logic [1:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [WIDTH-1:0] result_q,
    output logic             cout_q
);

    // Carry chain: w_carry[0] is the external carry-in, w_carry[WIDTH] the MSB carry-out
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            alu_bit u_bit (
                .a         (a[i]),
                .b         (b[i]),
                .cin       (w_carry[i]),
                .b_invert  (b_invert),
                .operation (operation),
                .result    (w_result[i]),
                .cout      (w_carry[i+1])
            );
        end
    endgenerate

    assign result = w_result;
    assign cout   = w_carry[WIDTH];

    // Pipeline copy of the combinational outputs, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_result <= w_result;
            r_cout   <= w_carry[WIDTH];
        end
    end

    assign result_q = r_result;
    assign cout_q   = r_cout;

endmodule : alu_1bit_slice
`default_nettype wire

// File: tb/tb_alu_1bit_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_1bit_slice
// Description : Self-checking bench for alu_1bit_slice at WIDTH=1 and
//               WIDTH=24, directed vectors plus random stimulus against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_1bit_slice;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // WIDTH=1 instance
    logic [0:0]  a1 = '0, b1 = '0;
    logic        cin1 = 1'b0, binv1 = 1'b0;
    logic [1:0]  op1 = 2'b00;
    logic [0:0]  result1, result_q1;
    logic        cout1, cout_q1;

    // WIDTH=24 instance
    logic [23:0] a24 = '0, b24 = '0;
    logic        cin24 = 1'b0, binv24 = 1'b0;
    logic [1:0]  op24 = 2'b00;
    logic [23:0] result24, result_q24;
    logic        cout24, cout_q24;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_1bit_slice #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .b_invert(binv1),
        .operation(op1), .result(result1), .cout(cout1),
        .result_q(result_q1), .cout_q(cout_q1)
    );

    alu_1bit_slice #(.WIDTH(24)) u_dut24 (
        .clk(clk), .rst(rst), .a(a24), .b(b24), .cin(cin24), .b_invert(binv24),
        .operation(op24), .result(result24), .cout(cout24),
        .result_q(result_q24), .cout_q(cout_q24)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands
    function automatic void model(input int w, input logic [23:0] a, input logic [23:0] b,
                                  input logic cin, input logic binv, input logic [1:0] op,
                                  output logic [23:0] r, output logic co);
        logic [24:0] mask;
        logic [24:0] bb;
        logic [24:0] sum;
        mask = (25'd1 << w) - 25'd1;
        bb   = (binv ? ~{1'b0, b} : {1'b0, b}) & mask;
        sum  = {1'b0, a} + bb + {24'd0, cin};
        co   = sum[w];
        case (op)
            2'b00:   r = 24'(({1'b0, a} & bb) & mask);
            2'b01:   r = 24'(({1'b0, a} | bb) & mask);
            2'b10:   r = 24'(sum & mask);
            default: r = 24'(({1'b0, a} ^ bb) & mask);
        endcase
    endfunction

    // Inputs are already set (just after a falling edge); check both instances
    task automatic step(input bit rs);
        logic [23:0] er1, er24;
        logic        ec1, ec24;
        rst = rs;
        #1;
        model(1,  {23'd0, a1}, {23'd0, b1}, cin1, binv1, op1, er1, ec1);
        model(24, a24, b24, cin24, binv24, op24, er24, ec24);
        chk("result1", 32'(result1), 32'(er1));
        chk("cout1",   32'(cout1),   32'(ec1));
        chk("result24", 32'(result24), 32'(er24));
        chk("cout24",   32'(cout24),   32'(ec24));
        @(posedge clk);
        #1;
        chk("result_q1",  32'(result_q1),  rs ? 32'd0 : 32'(er1));
        chk("cout_q1",    32'(cout_q1),    rs ? 32'd0 : 32'(ec1));
        chk("result_q24", 32'(result_q24), rs ? 32'd0 : 32'(er24));
        chk("cout_q24",   32'(cout_q24),   rs ? 32'd0 : 32'(ec24));
        @(negedge clk);
    endtask

    // Directed WIDTH=1 vectors: {op[1:0], b_invert, a, b, cin, result, cout}
    localparam int NV = 22;
    logic [7:0] vec [NV] = '{
        8'b00_0_000_00, 8'b00_0_010_00, 8'b00_0_100_00, 8'b00_0_110_11,
        8'b01_0_000_00, 8'b01_0_010_10, 8'b01_0_100_10, 8'b01_0_110_11,
        8'b10_0_000_00, 8'b10_0_010_10, 8'b10_0_100_10, 8'b10_0_110_01, 8'b10_0_111_11,
        8'b10_1_001_01, 8'b10_1_011_10, 8'b10_1_101_11, 8'b10_1_111_01,
        8'b11_0_000_00, 8'b11_0_010_10, 8'b11_0_100_10, 8'b11_0_110_01,
        8'b00_0_000_00
    };

    initial begin
        @(negedge clk);
        // Reset: registered outputs must be zero after one reset edge
        step(1'b1);
        chk("rst_result_q1", 32'(result_q1), 32'd0);
        chk("rst_cout_q1",   32'(cout_q1),   32'd0);

        // Directed single-bit truth tables
        for (int i = 0; i < NV; i++) begin
            logic [7:0] v;
            v     = vec[i];
            op1   = v[7:6];
            binv1 = v[5];
            a1    = v[4];
            b1    = v[3];
            cin1  = v[2];
            #1;
            chk($sformatf("dir%0d_result", i), 32'(result1), 32'(v[1]));
            chk($sformatf("dir%0d_cout", i),   32'(cout1),   32'(v[0]));
            step(1'b0);
        end

        // Register latency: ADD 1+1+1 captured on the next edge
        op1 = 2'b10; binv1 = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reg_add_result_q", 32'(result_q1), 32'd1);
        chk("reg_add_cout_q",   32'(cout_q1),   32'd1);
        @(negedge clk);

        // 24-bit subtract with borrow: 5 - 7
        op24 = 2'b10; binv24 = 1'b1; cin24 = 1'b1; a24 = 24'h000005; b24 = 24'h000007;
        #1;
        chk("sub24_result", 32'(result24), 32'h00FFFFFE);
        chk("sub24_cout",   32'(cout24),   32'd0);
        step(1'b0);
        chk("sub24_result_q", 32'(result_q24), 32'h00FFFFFE);
        chk("sub24_cout_q",   32'(cout_q24),   32'd0);

        // 24-bit boundary: max + 1 wraps with carry
        op24 = 2'b10; binv24 = 1'b0; cin24 = 1'b1; a24 = 24'hFFFFFF; b24 = 24'h000000;
        #1;
        chk("wrap24_result", 32'(result24), 32'd0);
        chk("wrap24_cout",   32'(cout24),   32'd1);
        step(1'b0);

        // Random stimulus with occasional reset mid-operation
        for (int i = 0; i < 400; i++) begin
            a1     = 1'($urandom);
            b1     = 1'($urandom);
            cin1   = 1'($urandom);
            binv1  = 1'($urandom);
            op1    = 2'($urandom);
            a24    = 24'($urandom);
            b24    = ($urandom_range(0, 7) == 0) ? a24 : 24'($urandom);
            cin24  = 1'($urandom);
            binv24 = 1'($urandom);
            op24   = 2'($urandom);
            step($urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_alu_1bit_slice
`default_nettype wire
